// File: rtl/hazard_scoreboard_if.sv
// Stage-control and hazard-result bundle between the MIPS datapath and hazard_scoreboard.
interface hazard_scoreboard_if #(
  parameter int unsigned AW = 5
);
  logic [AW-1:0] rsD, rtD, rsE, rtE;
  logic [AW-1:0] WriteRegE, WriteRegM, WriteRegW;
  logic          RegWriteE, RegWriteM, RegWriteW;
  logic          MemToRegE, MemToRegM;
  logic          BranchD, MduOpD, MduStartE;
  logic [AW-1:0] MduDstE;
  logic          ForwardaD, ForwardbD;
  logic [1:0]    ForwardaE, ForwardbE;
  logic          StallF, StallD, FlushE;
  logic          MduBusy, MduWb;
  logic [AW-1:0] MduWbReg;

  modport master (
    output rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM,
           BranchD, MduOpD, MduStartE, MduDstE,
    input  ForwardaD, ForwardbD, ForwardaE, ForwardbE,
           StallF, StallD, FlushE, MduBusy, MduWb, MduWbReg
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM,
           BranchD, MduOpD, MduStartE, MduDstE,
    output ForwardaD, ForwardbD, ForwardaE, ForwardbE,
           StallF, StallD, FlushE, MduBusy, MduWb, MduWbReg
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// 5-stage MIPS hazard unit with a one-entry scoreboard for a multi-cycle MDU.
// Optional stall performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_scoreboard #(
  parameter int unsigned AW      = 5,
  parameter int unsigned MDU_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_scoreboard_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] MduStallCnt
`endif
);

  localparam int unsigned   CW       = $clog2(MDU_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [AW-1:0] dst;

  logic mduLate;
  logic lwStall, brStall, mduStall, mduBusyStall, stall;

  function automatic logic [1:0] fwdE(
    input logic [AW-1:0] src,
    input logic [AW-1:0] wrM,
    input logic          rwM,
    input logic [AW-1:0] wrW,
    input logic          rwW
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (rwM && (src == wrM))      sel = 2'b10;
      else if (rwW && (src == wrW)) sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    hz.ForwardaD = (hz.rsD != '0) && (hz.rsD == hz.WriteRegM) && hz.RegWriteM;
    hz.ForwardbD = (hz.rtD != '0) && (hz.rtD == hz.WriteRegM) && hz.RegWriteM;
    hz.ForwardaE = fwdE(hz.rsE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
    hz.ForwardbE = fwdE(hz.rtE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
  end

  // Stalls only while the result is still 2+ cycles away; in the MduWb cycle
  // the write-through regfile already supplies the value.
  always_comb begin
    mduLate      = busy && (cnt >= CNT_TWO);
    lwStall      = hz.MemToRegE && (hz.WriteRegE != '0) &&
                   ((hz.WriteRegE == hz.rsD) || (hz.WriteRegE == hz.rtD));
    brStall      = hz.BranchD &&
                   ((hz.RegWriteE && (hz.WriteRegE != '0) &&
                     ((hz.WriteRegE == hz.rsD) || (hz.WriteRegE == hz.rtD))) ||
                    (hz.MemToRegM && (hz.WriteRegM != '0) &&
                     ((hz.WriteRegM == hz.rsD) || (hz.WriteRegM == hz.rtD))));
    mduStall     = mduLate && (dst != '0) && ((dst == hz.rsD) || (dst == hz.rtD));
    mduBusyStall = hz.MduOpD && mduLate;
    stall        = lwStall || brStall || mduStall || mduBusyStall;
  end

  assign hz.StallF   = stall;
  assign hz.StallD   = stall;
  assign hz.FlushE   = stall;
  assign hz.MduBusy  = busy;
  assign hz.MduWb    = busy && (cnt == CNT_ONE);
  assign hz.MduWbReg = busy ? dst : '0;

  // A new issue overrides the retiring op in its MduWb cycle; the countdown
  // is free-running and ignores pipeline stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      dst  <= '0;
    end else if (hz.MduStartE) begin
      busy <= 1'b1;
      cnt  <= CNT_LOAD;
      dst  <= hz.MduDstE;
    end else if (busy) begin
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE) begin
        busy <= 1'b0;
        dst  <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCnt    <= '0;
      MduStallCnt <= '0;
    end else begin
      if (stall)                    StallCnt    <= StallCnt + 32'd1;
      if (mduStall || mduBusyStall) MduStallCnt <= MduStallCnt + 32'd1;
    end
  end
`endif

endmodule
